ps2_key_event_queue: RTL and testbench
======================================

Name: ps2_key_event_queue

Overview:
- Parametrised successor to the keyboard scan-code decoder. Consumes the byte stream from the PS/2 controller and assembles E0/F0 prefixes into 9-bit key codes.
- Maintains a 512-bit key-down bitmap and a held-key counter.
- Queues every make/break event in a FIFO with a valid/ready handshake, so consumers (game FSMs, text entry) never miss keystrokes arriving faster than they poll.

Parameters:
- DEPTH, 8, event FIFO depth; power of two, minimum 2.
- PTR_W, 3, log2(DEPTH); FIFO pointer width.
- HELD_W, 4, width of keys_held; saturates at 2^HELD_W-1.
- REQUIRE_BAT, 1, 1 = ignore all bytes until 0xAA is received; 0 = start in READY.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- rx_byte  input  8  scan-code byte from the PS/2 controller.
- rx_valid  input  1  one-cycle strobe per received byte.
- evt_ready  input  1  consumer accepts the head event.
- evt_valid  output  1  FIFO non-empty.
- evt_data  output  11  {repeat, brk, ext, code[7:0]} of the head event; low 9 bits equal the key index.
- key_down  output  512  bit i = key index i currently held.
- keys_held  output  HELD_W  number of keys held, saturating.
- fifo_level  output  PTR_W+1  entries currently queued.
- overflow  output  1  sticky; set when an event is dropped because the FIFO is full.
- overflow_clr  input  1  clears overflow.
- kb_ready  output  1  BAT (0xAA) seen, or REQUIRE_BAT=0.

Behaviour:
- Reset values:
  - All outputs 0, except kb_ready = !REQUIRE_BAT.
  - FIFO empty, bitmap cleared.
  - Parser goes to INIT if REQUIRE_BAT, else READY.
- Bytes are examined only in cycles with rx_valid=1. All state is held otherwise.
- Parser states: INIT, READY, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
  - INIT: 0xAA -> READY and kb_ready=1; any other byte is ignored.
  - READY: 0xE0 -> EXT; 0xF0 -> BRK; any other data byte completes a make with ext=0.
  - EXT: 0xF0 -> EXT_BRK; 0xE0 -> stay in EXT; a data byte completes a make with ext=1.
  - BRK: a data byte completes a break with ext=0.
  - EXT_BRK: a data byte completes a break with ext=1.
  - After a completion the parser returns to READY.
- Special bytes, in any state other than INIT:
  - 0xAA: clear the bitmap and keys_held, drop pending prefixes, go to READY. No event is queued.
  - 0x00 or 0xFF (controller error/overrun): drop prefixes, go to READY, no event.
  - 0xFA, 0xFE, 0xEE, 0xE1 in READY: ignored.
- Make completion, key index k = {ext, byte}:
  - If key_down[k]=0: set the bit, increment keys_held (saturating), push an event with repeat=0.
  - If key_down[k]=1: this is a typematic repeat; see Optional Feature.
- Break completion:
  - If key_down[k]=1: clear the bit, decrement keys_held, push an event with brk=1.
  - If key_down[k]=0: push the event; bitmap and counter are unchanged (no underflow).
- Latency: final byte strobed in cycle T -> key_down, keys_held and the FIFO write all update at the edge ending T. evt_valid is high in T+1 when the FIFO was empty. There is no bypass path.
- FIFO handshake:
  - Pop occurs when evt_valid && evt_ready.
  - evt_data is held stable while evt_valid && !evt_ready.
- Push while full and no pop: the event is dropped, overflow is set, and the bitmap is still updated.
- Push and pop in the same cycle: both succeed when full or non-empty, and the level is unchanged.
- Pointers wrap modulo DEPTH.
- overflow_clr together with a dropping push in the same cycle: overflow stays set.
- Reset mid-sequence, e.g. between E0 and the data byte: the prefix is lost and the FIFO is flushed.

Optional Feature:
- Macro: KBD_TYPEMATIC_FILTER_EN.
- Defined: a make for an already-held key is discarded. No push occurs and no state changes; only the parser returns to READY.
- Undefined: the event is pushed with repeat=1, and the bitmap and counter are unchanged.

Test Plan:
- REQUIRE_BAT=1: send 0x1C before 0xAA -> no event, kb_ready=0. Then send 0xAA, 0x1C -> kb_ready=1, evt_data=0x01C, key_down[0x01C]=1, keys_held=1.
- Send E0 75, then E0 F0 75 with evt_ready=1 -> two events, 0x175 then 0x375 (brk=1, ext=1). key_down[0x175] goes 1 then 0.
- Send 1C 1C 1C (repeat) -> filter undefined: three events, the last two with evt_data[10]=1. Filter defined: exactly one event.
- evt_ready=0 with DEPTH=8: send 9 makes of distinct keys -> fifo_level=8, overflow=1, all 9 bitmap bits set, head=first key. Pulse overflow_clr -> overflow=0.
- FIFO full: push and pop in the same cycle -> fifo_level stays 8, and the popped data equals the oldest entry.
- Hold 3 keys, then send 0xAA -> key_down=0, keys_held=0, no event queued. Then send F0 1C -> break event pushed, keys_held stays 0.

Source files
------------

// File: rtl/ps2_key_event_queue.sv
// PS/2 scan-code parser with a 512-bit key-down bitmap, held-key counter and event FIFO.
// Optional: define KBD_TYPEMATIC_FILTER_EN to discard makes for keys already held.
module ps2_key_event_queue #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned PTR_W       = 3,
    parameter int unsigned HELD_W      = 4,
    parameter int unsigned REQUIRE_BAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    input  logic              evt_ready,
    output logic              evt_valid,
    output logic [10:0]       evt_data,
    output logic [511:0]      key_down,
    output logic [HELD_W-1:0] keys_held,
    output logic [PTR_W:0]    fifo_level,
    output logic              overflow,
    input  logic              overflow_clr,
    output logic              kb_ready
);

    typedef enum logic [2:0] {
        StInit,
        StReady,
        StExt,
        StBrk,
        StExtBrk
    } state_e;

    localparam logic [PTR_W:0]    FifoFull = (PTR_W + 1)'(DEPTH);
    localparam logic [HELD_W-1:0] HeldMax  = {HELD_W{1'b1}};
    localparam logic              BatReq   = (REQUIRE_BAT != 0);
    localparam state_e            StReset  = BatReq ? StInit : StReady;

    state_e              state_q, state_d;
    logic                kb_ready_q, kb_ready_d;
    logic [511:0]        key_down_q, key_down_d;
    logic [HELD_W-1:0]   held_q, held_d;
    logic                overflow_q, overflow_d;

    logic [10:0]         mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]      count_q, count_d;

    logic                is_data;
    logic                is_brk;
    logic                is_ext;
    logic [8:0]          key_idx;
    logic                push;
    logic [10:0]         push_data;
    logic                pop;
    logic                full;
    logic                do_push;
    logic                drop;

    // Prefix parser and bitmap/counter next state
    always_comb begin
        state_d    = state_q;
        kb_ready_d = kb_ready_q;
        key_down_d = key_down_q;
        held_d     = held_q;
        is_data    = 1'b0;
        is_brk     = 1'b0;
        is_ext     = 1'b0;
        push       = 1'b0;
        push_data  = '0;
        key_idx    = '0;

        if (rx_valid) begin
            if (state_q == StInit) begin
                if (rx_byte == 8'hAA) begin
                    state_d    = StReady;
                    kb_ready_d = 1'b1;
                end
            end else if (rx_byte == 8'hAA) begin
                // Keyboard self-test: every key is implicitly released
                state_d    = StReady;
                key_down_d = '0;
                held_d     = '0;
            end else if (rx_byte == 8'h00 || rx_byte == 8'hFF) begin
                state_d = StReady;
            end else begin
                case (state_q)
                    StReady: begin
                        if (rx_byte == 8'hE0) begin
                            state_d = StExt;
                        end else if (rx_byte == 8'hF0) begin
                            state_d = StBrk;
                        end else if (rx_byte == 8'hFA || rx_byte == 8'hFE ||
                                     rx_byte == 8'hEE || rx_byte == 8'hE1) begin
                            state_d = StReady;
                        end else begin
                            is_data = 1'b1;
                        end
                    end
                    StExt: begin
                        if (rx_byte == 8'hF0) begin
                            state_d = StExtBrk;
                        end else if (rx_byte != 8'hE0) begin
                            is_data = 1'b1;
                            is_ext  = 1'b1;
                        end
                    end
                    StBrk: begin
                        is_data = 1'b1;
                        is_brk  = 1'b1;
                    end
                    StExtBrk: begin
                        is_data = 1'b1;
                        is_brk  = 1'b1;
                        is_ext  = 1'b1;
                    end
                    default: state_d = StReady;
                endcase
            end
        end

        if (is_data) begin
            state_d = StReady;
            key_idx = {is_ext, rx_byte};
            if (is_brk) begin
                push      = 1'b1;
                push_data = {1'b0, 1'b1, is_ext, rx_byte};
                if (key_down_q[key_idx]) begin
                    key_down_d[key_idx] = 1'b0;
                    if (held_q != '0) begin
                        held_d = held_q - 1'b1;
                    end
                end
            end else if (!key_down_q[key_idx]) begin
                push                = 1'b1;
                push_data           = {1'b0, 1'b0, is_ext, rx_byte};
                key_down_d[key_idx] = 1'b1;
                if (held_q != HeldMax) begin
                    held_d = held_q + 1'b1;
                end
            end else begin
`ifdef KBD_TYPEMATIC_FILTER_EN
                push = 1'b0;
`else
                push      = 1'b1;
                push_data = {1'b1, 1'b0, is_ext, rx_byte};
`endif
            end
        end
    end

    // FIFO control: a full FIFO still accepts a push when the head pops in the same cycle
    always_comb begin
        pop        = evt_valid && evt_ready;
        full       = (count_q == FifoFull);
        do_push    = push && (!full || pop);
        drop       = push && full && !pop;
        count_d    = count_q;
        if (do_push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
        overflow_d = overflow_q;
        if (overflow_clr) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StReset;
            kb_ready_q <= !BatReq;
            key_down_q <= '0;
            held_q     <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            kb_ready_q <= kb_ready_d;
            key_down_q <= key_down_d;
            held_q     <= held_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset; evt_data is masked while empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_comb begin
        evt_valid  = (count_q != '0);
        evt_data   = evt_valid ? mem[rd_ptr_q] : '0;
        key_down   = key_down_q;
        keys_held  = held_q;
        fifo_level = count_q;
        overflow   = overflow_q;
        kb_ready   = kb_ready_q;
    end

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed self-checking bench for ps2_key_event_queue (DEPTH=8, REQUIRE_BAT=1).
module tb_ps2_key_event_queue;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_byte;
    logic         rx_valid;
    logic         evt_ready;
    logic         evt_valid;
    logic [10:0]  evt_data;
    logic [511:0] key_down;
    logic [3:0]   keys_held;
    logic [3:0]   fifo_level;
    logic         overflow;
    logic         overflow_clr;
    logic         kb_ready;

    int tests  = 0;
    int errors = 0;

    ps2_key_event_queue #(
        .DEPTH      (8),
        .PTR_W      (3),
        .HELD_W     (4),
        .REQUIRE_BAT(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .evt_ready   (evt_ready),
        .evt_valid   (evt_valid),
        .evt_data    (evt_data),
        .key_down    (key_down),
        .keys_held   (keys_held),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .overflow_clr(overflow_clr),
        .kb_ready    (kb_ready)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge after the byte was consumed
    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pop_one();
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_byte = '0; evt_ready = 1'b0; overflow_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tests++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset evt_valid got %0h want 0", evt_valid); end
        tests++; if (evt_data !== 11'h0) begin errors++; $display("FAIL reset evt_data got %0h want 0", evt_data); end
        tests++; if (key_down !== '0) begin errors++; $display("FAIL reset key_down not zero"); end
        tests++; if (keys_held !== 4'd0) begin errors++; $display("FAIL reset keys_held got %0d want 0", keys_held); end
        tests++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset fifo_level got %0d want 0", fifo_level); end
        tests++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow got %0h want 0", overflow); end
        tests++; if (kb_ready !== 1'b0) begin errors++; $display("FAIL reset kb_ready got %0h want 0", kb_ready); end
    endtask

    task automatic test_bat();
        send_byte(8'h1C);
        tests++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL bat pre-AA level got %0d want 0", fifo_level); end
        tests++; if (kb_ready !== 1'b0) begin errors++; $display("FAIL bat pre-AA kb_ready got %0h want 0", kb_ready); end
        send_byte(8'hAA);
        tests++; if (kb_ready !== 1'b1) begin errors++; $display("FAIL bat kb_ready got %0h want 1", kb_ready); end
        tests++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL bat AA level got %0d want 0", fifo_level); end
        send_byte(8'h1C);
        tests++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL bat make evt_valid got %0h want 1", evt_valid); end
        tests++; if (evt_data !== 11'h01C) begin errors++; $display("FAIL bat make evt_data got %0h want 01c", evt_data); end
        tests++; if (key_down[9'h01C] !== 1'b1) begin errors++; $display("FAIL bat key_down[1c] got 0 want 1"); end
        tests++; if (keys_held !== 4'd1) begin errors++; $display("FAIL bat keys_held got %0d want 1", keys_held); end
        pop_one();
        tests++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL bat pop evt_valid got %0h want 0", evt_valid); end
        send_byte(8'hF0); send_byte(8'h1C);
        tests++; if (evt_data !== 11'h21C) begin errors++; $display("FAIL bat break evt_data got %0h want 21c", evt_data); end
        tests++; if (keys_held !== 4'd0) begin errors++; $display("FAIL bat break keys_held got %0d want 0", keys_held); end
        pop_one();
    endtask

    task automatic test_ext();
        send_byte(8'hE0); send_byte(8'h75);
        tests++; if (evt_data !== 11'h175) begin errors++; $display("FAIL ext make evt_data got %0h want 175", evt_data); end
        tests++; if (key_down[9'h175] !== 1'b1) begin errors++; $display("FAIL ext key_down[175] got 0 want 1"); end
        tests++; if (key_down[9'h075] !== 1'b0) begin errors++; $display("FAIL ext key_down[075] got 1 want 0"); end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        tests++; if (fifo_level !== 4'd2) begin errors++; $display("FAIL ext level got %0d want 2", fifo_level); end
        tests++; if (key_down[9'h175] !== 1'b0) begin errors++; $display("FAIL ext break key_down[175] got 1 want 0"); end
        pop_one();
        tests++; if (evt_data !== 11'h375) begin errors++; $display("FAIL ext break evt_data got %0h want 375", evt_data); end
        pop_one();
    endtask

    task automatic test_repeat();
        send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
        tests++; if (keys_held !== 4'd1) begin errors++; $display("FAIL repeat keys_held got %0d want 1", keys_held); end
`ifdef KBD_TYPEMATIC_FILTER_EN
        tests++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL repeat level got %0d want 1", fifo_level); end
        pop_one();
`else
        tests++; if (fifo_level !== 4'd3) begin errors++; $display("FAIL repeat level got %0d want 3", fifo_level); end
        tests++; if (evt_data !== 11'h01C) begin errors++; $display("FAIL repeat first got %0h want 01c", evt_data); end
        pop_one();
        tests++; if (evt_data !== 11'h41C) begin errors++; $display("FAIL repeat second got %0h want 41c", evt_data); end
        pop_one();
        tests++; if (evt_data !== 11'h41C) begin errors++; $display("FAIL repeat third got %0h want 41c", evt_data); end
        pop_one();
`endif
        send_byte(8'hF0); send_byte(8'h1C);
        tests++; if (keys_held !== 4'd0) begin errors++; $display("FAIL repeat release keys_held got %0d want 0", keys_held); end
        pop_one();
        tests++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL repeat drain level got %0d want 0", fifo_level); end
    endtask

    task automatic test_overflow();
        logic [7:0] keys [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
        logic [7:0] order [8] = '{8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h4D};
        for (int i = 0; i < 9; i++) send_byte(keys[i]);
        tests++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL ovf level got %0d want 8", fifo_level); end
        tests++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf flag got %0h want 1", overflow); end
        tests++; if (keys_held !== 4'd9) begin errors++; $display("FAIL ovf keys_held got %0d want 9", keys_held); end
        tests++; if (evt_data !== 11'h015) begin errors++; $display("FAIL ovf head got %0h want 015", evt_data); end
        for (int i = 0; i < 9; i++) begin
            tests++;
            if (key_down[{1'b0, keys[i]}] !== 1'b1) begin
                errors++; $display("FAIL ovf bitmap key %0h got 0 want 1", keys[i]);
            end
        end
        overflow_clr = 1'b1; @(negedge clk); overflow_clr = 1'b0;
        tests++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf clear got %0h want 0", overflow); end
        // Clear and drop in the same cycle: drop wins
        overflow_clr = 1'b1; send_byte(8'h4B); overflow_clr = 1'b0;
        tests++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf clr+drop got %0h want 1", overflow); end
        tests++; if (key_down[9'h04B] !== 1'b1) begin errors++; $display("FAIL ovf dropped key bitmap got 0 want 1"); end
        tests++; if (keys_held !== 4'd10) begin errors++; $display("FAIL ovf dropped keys_held got %0d want 10", keys_held); end
        // Push and pop together while full
        evt_ready = 1'b1; rx_byte = 8'h4D; rx_valid = 1'b1;
        #1;
        tests++; if (evt_data !== 11'h015) begin errors++; $display("FAIL full pushpop popped got %0h want 015", evt_data); end
        @(negedge clk);
        evt_ready = 1'b0; rx_valid = 1'b0;
        tests++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL full pushpop level got %0d want 8", fifo_level); end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (evt_data !== {3'b000, order[i]}) begin
                errors++; $display("FAIL ovf drain %0d got %0h want %0h", i, evt_data, order[i]);
            end
            pop_one();
        end
        tests++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL ovf drained evt_valid got %0h want 0", evt_valid); end
    endtask

    task automatic test_bat_clear();
        send_byte(8'hAA);
        tests++; if (key_down !== '0) begin errors++; $display("FAIL batclr key_down not zero"); end
        tests++; if (keys_held !== 4'd0) begin errors++; $display("FAIL batclr keys_held got %0d want 0", keys_held); end
        tests++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL batclr level got %0d want 0", fifo_level); end
        send_byte(8'hF0); send_byte(8'h1C);
        tests++; if (evt_data !== 11'h21C) begin errors++; $display("FAIL batclr break got %0h want 21c", evt_data); end
        tests++; if (keys_held !== 4'd0) begin errors++; $display("FAIL batclr break keys_held got %0d want 0", keys_held); end
        pop_one();
    endtask

    task automatic test_reset_mid();
        send_byte(8'h16); send_byte(8'hE0);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        tests++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL rstmid level got %0d want 0", fifo_level); end
        tests++; if (kb_ready !== 1'b0) begin errors++; $display("FAIL rstmid kb_ready got %0h want 0", kb_ready); end
        send_byte(8'hAA); send_byte(8'h75);
        tests++; if (evt_data !== 11'h075) begin errors++; $display("FAIL rstmid evt_data got %0h want 075", evt_data); end
        pop_one();
        send_byte(8'hFA); send_byte(8'hE0); send_byte(8'h00); send_byte(8'h74);
        tests++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL special level got %0d want 1", fifo_level); end
        tests++; if (evt_data !== 11'h074) begin errors++; $display("FAIL special evt_data got %0h want 074", evt_data); end
        pop_one();
    endtask

    initial begin
        test_reset();
        test_bat();
        test_ext();
        test_repeat();
        test_overflow();
        test_bat_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
